// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi_pkg
// Summary  : Shared slice-mode enum and per-channel payload-width helpers.
// Revision : 1.0
// ============================================================================
package axi_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_HALF   = 2'd1,
        SLICE_FULL   = 2'd2
    } slice_mode_e;

    localparam int c_AXI_LEN_W   = 8;
    localparam int c_AXI_SIZE_W  = 3;
    localparam int c_AXI_BURST_W = 2;

    // AW and AR share the same layout: {ID, ADDR, LEN, SIZE, BURST}
    function automatic int aw_payload_width(input int id_w, input int addr_w);
        return id_w + addr_w + c_AXI_LEN_W + c_AXI_SIZE_W + c_AXI_BURST_W;
    endfunction

    function automatic int ar_payload_width(input int id_w, input int addr_w);
        return id_w + addr_w + c_AXI_LEN_W + c_AXI_SIZE_W + c_AXI_BURST_W;
    endfunction

    function automatic int w_payload_width(input int data_w);
        return data_w + (data_w / 8) + 1;
    endfunction

    function automatic int b_payload_width(input int id_w);
        return id_w;
    endfunction

    function automatic int r_payload_width(input int id_w, input int data_w);
        return id_w + data_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_if.sv
`default_nettype none
// ============================================================================
// Interface: axi_if
// Summary  : Reduced AXI bundle (AW/W/B/AR/R) with slave (s) and master (m) views.
// Revision : 1.0
// ============================================================================
interface axi_if
    import axi_pkg::*;
#(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ID_W_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [c_AXI_LEN_W-1:0]    awlen;
    logic [c_AXI_SIZE_W-1:0]   awsize;
    logic [c_AXI_BURST_W-1:0]  awburst;
    logic                      awvalid;
    logic                      awready;

    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [ID_W_WIDTH-1:0]     bid;
    logic                      bvalid;
    logic                      bready;

    logic [ID_R_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [c_AXI_LEN_W-1:0]    arlen;
    logic [c_AXI_SIZE_W-1:0]   arsize;
    logic [c_AXI_BURST_W-1:0]  arburst;
    logic                      arvalid;
    logic                      arready;

    logic [ID_R_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    // Slave view: the side a master connects to.
    modport s (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready
    );

    modport m (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready
    );

endinterface
`default_nettype wire

// File: rtl/axi_slice_chan.sv
`default_nettype none
// ============================================================================
// Module   : axi_slice_chan
// Summary  : One valid/ready channel stage: bypass wires, half buffer or 2-entry skid.
// Revision : 1.0
// ============================================================================
module axi_slice_chan
    import axi_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter slice_mode_e MODE  = SLICE_FULL
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] dst_data
);

    generate
        if (MODE == SLICE_BYPASS) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = aclk ^ aresetn;

            assign dst_valid = src_valid;
            assign dst_data  = src_data;
            assign src_ready = dst_ready;

        end else if (MODE == SLICE_HALF) begin : g_half
            localparam logic c_EMPTY = 1'b0;
            localparam logic c_FULL  = 1'b1;

            logic             r_state;
            logic             w_state_nxt;
            logic             r_src_ready;
            logic             w_src_xfer;
            logic             w_dst_xfer;
            logic             w_dst_valid;
            logic             w_load;
            logic [WIDTH-1:0] r_data;

            assign w_src_xfer = src_valid & r_src_ready;
            assign w_dst_xfer = w_dst_valid & dst_ready;

            // Ready is a flop so it reads 0 through reset and rises one edge later.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_state     <= c_EMPTY;
                    r_src_ready <= 1'b0;
                end else begin
                    r_state     <= w_state_nxt;
                    r_src_ready <= (w_state_nxt == c_EMPTY);
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_EMPTY: if (w_src_xfer) w_state_nxt = c_FULL;
                    c_FULL:  if (w_dst_xfer) w_state_nxt = c_EMPTY;
                    default: w_state_nxt = c_EMPTY;
                endcase
            end

            always_comb begin
                w_dst_valid = (r_state == c_FULL);
                w_load      = (r_state == c_EMPTY) && w_src_xfer;
            end

            always_ff @(posedge aclk) begin
                if (w_load) begin
                    r_data <= src_data;
                end
            end

            assign src_ready = r_src_ready;
            assign dst_valid = w_dst_valid;
            assign dst_data  = r_data;

        end else begin : g_full
            localparam logic [1:0] c_EMPTY = 2'd0;
            localparam logic [1:0] c_ONE   = 2'd1;
            localparam logic [1:0] c_TWO   = 2'd2;

            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic             r_src_ready;
            logic             w_src_xfer;
            logic             w_dst_xfer;
            logic             w_dst_valid;
            logic             w_load_out;
            logic             w_load_skid;
            logic             w_promote;
            logic [WIDTH-1:0] r_out;
            logic [WIDTH-1:0] r_skid;

            assign w_src_xfer = src_valid & r_src_ready;
            assign w_dst_xfer = w_dst_valid & dst_ready;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_state     <= c_EMPTY;
                    r_src_ready <= 1'b0;
                end else begin
                    r_state     <= w_state_nxt;
                    r_src_ready <= (w_state_nxt != c_TWO);
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_EMPTY: begin
                        if (w_src_xfer) w_state_nxt = c_ONE;
                    end
                    c_ONE: begin
                        if (w_src_xfer && !w_dst_xfer)      w_state_nxt = c_TWO;
                        else if (!w_src_xfer && w_dst_xfer) w_state_nxt = c_EMPTY;
                    end
                    c_TWO: begin
                        if (w_dst_xfer) w_state_nxt = c_ONE;
                    end
                    default: w_state_nxt = c_EMPTY;
                endcase
            end

            // The skid entry only fills when the output is stalled; it drains into r_out.
            always_comb begin
                w_dst_valid = (r_state == c_ONE) || (r_state == c_TWO);
                w_load_out  = 1'b0;
                w_load_skid = 1'b0;
                w_promote   = 1'b0;
                case (r_state)
                    c_EMPTY: begin
                        w_load_out = w_src_xfer;
                    end
                    c_ONE: begin
                        w_load_out  = w_src_xfer && w_dst_xfer;
                        w_load_skid = w_src_xfer && !w_dst_xfer;
                    end
                    c_TWO: begin
                        w_promote = w_dst_xfer;
                    end
                    default: begin
                        w_load_out = 1'b0;
                    end
                endcase
            end

            always_ff @(posedge aclk) begin
                if (w_promote) begin
                    r_out <= r_skid;
                end else if (w_load_out) begin
                    r_out <= src_data;
                end
                if (w_load_skid) begin
                    r_skid <= src_data;
                end
            end

            assign src_ready = r_src_ready;
            assign dst_valid = w_dst_valid;
            assign dst_data  = r_out;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_reg_slice.sv
`default_nettype none
// ============================================================================
// Module   : axi_reg_slice
// Summary  : AXI register slice; packs each channel into one axi_slice_chan stage.
// Revision : 1.0
// ============================================================================
module axi_reg_slice
    import axi_pkg::*;
#(
    parameter int          ID_W_WIDTH = 4,
    parameter int          ID_R_WIDTH = 4,
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter slice_mode_e AW_MODE    = SLICE_FULL,
    parameter slice_mode_e W_MODE     = SLICE_FULL,
    parameter slice_mode_e B_MODE     = SLICE_FULL,
    parameter slice_mode_e AR_MODE    = SLICE_FULL,
    parameter slice_mode_e R_MODE     = SLICE_FULL
) (
    input  logic aclk,
    input  logic aresetn,
    axi_if.s     s,
    axi_if.m     m
);

    localparam int c_AW_W = aw_payload_width(ID_W_WIDTH, ADDR_WIDTH);
    localparam int c_W_W  = w_payload_width(DATA_WIDTH);
    localparam int c_B_W  = b_payload_width(ID_W_WIDTH);
    localparam int c_AR_W = ar_payload_width(ID_R_WIDTH, ADDR_WIDTH);
    localparam int c_R_W  = r_payload_width(ID_R_WIDTH, DATA_WIDTH);

    logic [c_AW_W-1:0] w_aw_src, w_aw_dst;
    logic [c_W_W-1:0]  w_w_src,  w_w_dst;
    logic [c_B_W-1:0]  w_b_src,  w_b_dst;
    logic [c_AR_W-1:0] w_ar_src, w_ar_dst;
    logic [c_R_W-1:0]  w_r_src,  w_r_dst;

    // Request channels: s -> m
    assign w_aw_src = {s.awid, s.awaddr, s.awlen, s.awsize, s.awburst};
    assign {m.awid, m.awaddr, m.awlen, m.awsize, m.awburst} = w_aw_dst;

    assign w_w_src = {s.wdata, s.wstrb, s.wlast};
    assign {m.wdata, m.wstrb, m.wlast} = w_w_dst;

    assign w_ar_src = {s.arid, s.araddr, s.arlen, s.arsize, s.arburst};
    assign {m.arid, m.araddr, m.arlen, m.arsize, m.arburst} = w_ar_dst;

    // Response channels: m -> s
    assign w_b_src = m.bid;
    assign s.bid   = w_b_dst;

    assign w_r_src = {m.rid, m.rdata, m.rlast};
    assign {s.rid, s.rdata, s.rlast} = w_r_dst;

    axi_slice_chan #(.WIDTH(c_AW_W), .MODE(AW_MODE)) u_aw (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .src_valid (s.awvalid),
        .src_ready (s.awready),
        .src_data  (w_aw_src),
        .dst_valid (m.awvalid),
        .dst_ready (m.awready),
        .dst_data  (w_aw_dst)
    );

    axi_slice_chan #(.WIDTH(c_W_W), .MODE(W_MODE)) u_w (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .src_valid (s.wvalid),
        .src_ready (s.wready),
        .src_data  (w_w_src),
        .dst_valid (m.wvalid),
        .dst_ready (m.wready),
        .dst_data  (w_w_dst)
    );

    axi_slice_chan #(.WIDTH(c_B_W), .MODE(B_MODE)) u_b (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .src_valid (m.bvalid),
        .src_ready (m.bready),
        .src_data  (w_b_src),
        .dst_valid (s.bvalid),
        .dst_ready (s.bready),
        .dst_data  (w_b_dst)
    );

    axi_slice_chan #(.WIDTH(c_AR_W), .MODE(AR_MODE)) u_ar (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .src_valid (s.arvalid),
        .src_ready (s.arready),
        .src_data  (w_ar_src),
        .dst_valid (m.arvalid),
        .dst_ready (m.arready),
        .dst_data  (w_ar_dst)
    );

    axi_slice_chan #(.WIDTH(c_R_W), .MODE(R_MODE)) u_r (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .src_valid (m.rvalid),
        .src_ready (m.rready),
        .src_data  (w_r_src),
        .dst_valid (s.rvalid),
        .dst_ready (s.rready),
        .dst_data  (w_r_dst)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_reg_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_reg_slice
// Summary  : Scoreboard bench for axi_reg_slice with mixed half/full/bypass channels.
// Revision : 1.0
// ============================================================================
module tb_axi_reg_slice;
    import axi_pkg::*;

    localparam int c_NCH        = 5;   // 0 AW, 1 W, 2 B, 3 AR, 4 R
    localparam int c_RAND_BEATS = 10000;

    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Channel-generic view: src is the producing side, dst the consuming side.
    logic        src_valid [c_NCH];
    logic        src_ready [c_NCH];
    logic [39:0] src_data  [c_NCH];
    logic        dst_valid [c_NCH];
    logic        dst_ready [c_NCH];
    logic [39:0] dst_data  [c_NCH];

    logic        src_hs    [c_NCH];
    logic        dst_hs    [c_NCH];
    int          dst_cnt   [c_NCH];
    logic        prev_dv   [c_NCH];
    logic        prev_dhs  [c_NCH];
    logic [39:0] prev_dd   [c_NCH];
    logic [39:0] exp_q     [c_NCH][$];
    logic [39:0] mon_exp;

    int checks   = 0;
    int failures = 0;

    axi_if #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) s_if ();
    axi_if #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) m_if ();

    assign s_if.awvalid = src_valid[0];
    assign src_ready[0] = s_if.awready;
    assign {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst} = src_data[0][32:0];
    assign dst_valid[0] = m_if.awvalid;
    assign m_if.awready = dst_ready[0];
    assign dst_data[0]  = {7'd0, m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst};

    assign s_if.wvalid  = src_valid[1];
    assign src_ready[1] = s_if.wready;
    assign {s_if.wdata, s_if.wstrb, s_if.wlast} = src_data[1][36:0];
    assign dst_valid[1] = m_if.wvalid;
    assign m_if.wready  = dst_ready[1];
    assign dst_data[1]  = {3'd0, m_if.wdata, m_if.wstrb, m_if.wlast};

    assign m_if.bvalid  = src_valid[2];
    assign src_ready[2] = m_if.bready;
    assign m_if.bid     = src_data[2][3:0];
    assign dst_valid[2] = s_if.bvalid;
    assign s_if.bready  = dst_ready[2];
    assign dst_data[2]  = {36'd0, s_if.bid};

    assign s_if.arvalid = src_valid[3];
    assign src_ready[3] = s_if.arready;
    assign {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst} = src_data[3][32:0];
    assign dst_valid[3] = m_if.arvalid;
    assign m_if.arready = dst_ready[3];
    assign dst_data[3]  = {7'd0, m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst};

    assign m_if.rvalid  = src_valid[4];
    assign src_ready[4] = m_if.rready;
    assign {m_if.rid, m_if.rdata, m_if.rlast} = src_data[4][36:0];
    assign dst_valid[4] = s_if.rvalid;
    assign s_if.rready  = dst_ready[4];
    assign dst_data[4]  = {3'd0, s_if.rid, s_if.rdata, s_if.rlast};

    axi_reg_slice #(
        .ID_W_WIDTH (4),
        .ID_R_WIDTH (4),
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .AW_MODE    (SLICE_HALF),
        .W_MODE     (SLICE_FULL),
        .B_MODE     (SLICE_FULL),
        .AR_MODE    (SLICE_BYPASS),
        .R_MODE     (SLICE_FULL)
    ) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .s       (s_if),
        .m       (m_if)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [39:0] payload_mask(input int c);
        int w;
        case (c)
            0, 3:    w = 4 + 16 + 8 + 3 + 2;
            1:       w = 32 + 4 + 1;
            2:       w = 4;
            default: w = 4 + 32 + 1;
        endcase
        return (40'd1 << w) - 40'd1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: at each negedge, what is visible is what the next edge will transfer.
    initial begin
        for (int c = 0; c < c_NCH; c++) begin
            src_hs[c] = 1'b0; dst_hs[c] = 1'b0; dst_cnt[c] = 0;
            prev_dv[c] = 1'b0; prev_dhs[c] = 1'b0; prev_dd[c] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                for (int c = 0; c < c_NCH; c++) begin
                    exp_q[c].delete();
                    src_hs[c] = 1'b0; dst_hs[c] = 1'b0;
                    prev_dv[c] = 1'b0; prev_dhs[c] = 1'b0;
                end
            end else begin
                for (int c = 0; c < c_NCH; c++) begin
                    if (prev_dv[c] && !prev_dhs[c]) begin
                        check_bit($sformatf("hold_valid_ch%0d", c), dst_valid[c], 1'b1);
                        check_data($sformatf("hold_data_ch%0d", c), 64'(dst_data[c]), 64'(prev_dd[c]));
                    end
                    src_hs[c] = src_valid[c] && src_ready[c];
                    dst_hs[c] = dst_valid[c] && dst_ready[c];
                    if (src_hs[c]) exp_q[c].push_back(src_data[c]);
                    if (dst_hs[c]) begin
                        dst_cnt[c]++;
                        if (exp_q[c].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat_ch%0d: actual=0x%0h required=no beat", c, dst_data[c]);
                        end else begin
                            mon_exp = exp_q[c].pop_front();
                            check_data($sformatf("payload_ch%0d", c), 64'(dst_data[c]), 64'(mon_exp));
                        end
                    end
                    prev_dv[c]  = dst_valid[c];
                    prev_dhs[c] = dst_hs[c];
                    prev_dd[c]  = dst_data[c];
                end
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    int          acc;
    int          n0;
    int          cyc;
    int          base;
    int          rand_beats;
    logic [63:0] rnd64;

    initial begin
        rst_n = 1'b0;
        for (int c = 0; c < c_NCH; c++) begin
            src_valid[c] = 1'b0; src_data[c] = '0; dst_ready[c] = 1'b1;
        end
        repeat (3) cycle();

        check_bit("rst_awready", s_if.awready, 1'b0);
        check_bit("rst_wready",  s_if.wready,  1'b0);
        check_bit("rst_bready",  m_if.bready,  1'b0);
        check_bit("rst_rready",  m_if.rready,  1'b0);
        check_bit("rst_awvalid", m_if.awvalid, 1'b0);
        check_bit("rst_wvalid",  m_if.wvalid,  1'b0);
        check_bit("rst_bvalid",  s_if.bvalid,  1'b0);
        check_bit("rst_rvalid",  s_if.rvalid,  1'b0);

        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check_bit("release_ready_before_edge", s_if.wready, 1'b0);
        cycle();
        check_bit("release_awready", s_if.awready, 1'b1);
        check_bit("release_wready",  s_if.wready,  1'b1);
        check_bit("release_bready",  m_if.bready,  1'b1);
        check_bit("release_rready",  m_if.rready,  1'b1);

        // AR bypass: combinational in both directions.
        src_valid[3] = 1'b1;
        src_data[3]  = {7'd0, 4'h3, 16'h1234, 8'd0, 3'd2, 2'd1};
        dst_ready[3] = 1'b0;
        #1;
        check_data("ar_bypass_addr", 64'(m_if.araddr), 64'h1234);
        check_bit("ar_bypass_valid", m_if.arvalid, 1'b1);
        check_bit("ar_bypass_ready_low", s_if.arready, 1'b0);
        dst_ready[3] = 1'b1;
        #1 check_bit("ar_bypass_ready_high", s_if.arready, 1'b1);
        cycle();
        src_valid[3] = 1'b0;

        // W full: 4 back-to-back beats, one cycle latency.
        for (int i = 0; i < 4; i++) begin
            src_valid[1] = 1'b1;
            src_data[1]  = {3'd0, 32'(i + 1), 4'hF, (i == 3)};
            check_bit("w_stream_src_ready", s_if.wready, 1'b1);
            cycle();
            check_bit("w_stream_valid", m_if.wvalid, 1'b1);
            check_data("w_stream_data", 64'(m_if.wdata), 64'(i + 1));
            check_bit("w_stream_last", m_if.wlast, (i == 3));
        end
        src_valid[1] = 1'b0;
        repeat (3) cycle();

        // R full: consumer stalled, third beat must wait in the source.
        n0 = dst_cnt[4];
        dst_ready[4] = 1'b0;
        src_valid[4] = 1'b1;
        src_data[4]  = {3'd0, 4'h1, 32'hA1, 1'b0};
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (src_hs[4]) begin
                acc++;
                if (acc == 1)      src_data[4] = {3'd0, 4'h2, 32'hA2, 1'b0};
                else if (acc == 2) src_data[4] = {3'd0, 4'h3, 32'hA3, 1'b1};
                else               src_valid[4] = 1'b0;
            end
        end
        check_int("r_bp_accepts", acc, 2);
        check_bit("r_bp_src_ready", m_if.rready, 1'b0);
        check_bit("r_bp_dst_valid", s_if.rvalid, 1'b1);
        check_data("r_bp_head", 64'(s_if.rdata), 64'hA1);
        dst_ready[4] = 1'b1;
        for (int k = 0; k < 10 && acc < 3; k++) begin
            cycle();
            if (src_hs[4]) begin
                acc++;
                if (acc == 3) src_valid[4] = 1'b0;
            end
        end
        check_int("r_release_accepts", acc, 3);
        repeat (4) cycle();
        check_int("r_release_delivered", dst_cnt[4] - n0, 3);
        check_int("r_release_queue_empty", exp_q[4].size(), 0);

        // AW half: continuous VALID, 4 addresses in 8 cycles.
        n0  = dst_cnt[0];
        acc = 0;
        src_valid[0] = 1'b1;
        src_data[0]  = {7'd0, 4'h1, 16'h0010, 8'd0, 3'd2, 2'd1};
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k == 0) check_bit("aw_half_ready_gap", s_if.awready, 1'b0);
            if (src_hs[0]) begin
                acc++;
                if (acc < 4) src_data[0] = {7'd0, 4'h1, 16'(16 * (acc + 1)), 8'd0, 3'd2, 2'd1};
                else         src_valid[0] = 1'b0;
            end
        end
        check_int("aw_half_accepts", acc, 4);
        check_int("aw_half_transfers", dst_cnt[0] - n0, 4);
        repeat (4) cycle();
        check_int("aw_half_no_dup", dst_cnt[0] - n0, 4);

        // B full filled to two entries, then reset.
        dst_ready[2] = 1'b0;
        src_valid[2] = 1'b1;
        src_data[2]  = 40'h5;
        acc = 0;
        for (int k = 0; k < 6 && acc < 2; k++) begin
            cycle();
            if (src_hs[2]) begin
                acc++;
                if (acc == 1) src_data[2] = 40'h6;
                else          src_valid[2] = 1'b0;
            end
        end
        check_int("b_fill_accepts", acc, 2);
        check_bit("b_two_src_ready", m_if.bready, 1'b0);
        check_data("b_two_head", 64'(s_if.bid), 64'h5);
        #2 rst_n = 1'b0;
        #1;
        check_bit("b_reset_valid_async", s_if.bvalid, 1'b0);
        check_bit("b_reset_ready", m_if.bready, 1'b0);
        dst_ready[2] = 1'b1;
        n0 = dst_cnt[2];
        repeat (2) cycle();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check_bit("b_release_ready_low", m_if.bready, 1'b0);
        cycle();
        check_bit("b_release_ready_high", m_if.bready, 1'b1);
        repeat (5) cycle();
        check_int("b_no_stale_beats", dst_cnt[2] - n0, 0);
        check_bit("b_no_stale_valid", s_if.bvalid, 1'b0);

        // Random traffic on every channel against the in-order queues.
        base = 0;
        for (int c = 0; c < c_NCH; c++) base += dst_cnt[c];
        rand_beats = 0;
        cyc = 0;
        while (rand_beats < c_RAND_BEATS && cyc < 40000) begin
            for (int c = 0; c < c_NCH; c++) begin
                if (!src_valid[c] || src_hs[c]) begin
                    src_valid[c] = ($urandom_range(0, 3) != 0);
                    rnd64        = {$urandom(), $urandom()};
                    src_data[c]  = rnd64[39:0] & payload_mask(c);
                end
                dst_ready[c] = ($urandom_range(0, 3) != 0);
            end
            cycle();
            cyc++;
            rand_beats = -base;
            for (int c = 0; c < c_NCH; c++) rand_beats += dst_cnt[c];
        end
        check_bit("random_beat_budget", (rand_beats >= c_RAND_BEATS), 1'b1);

        for (int c = 0; c < c_NCH; c++) dst_ready[c] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < c_NCH; c++) begin
                if (src_hs[c]) src_valid[c] = 1'b0;
            end
            cycle();
        end
        for (int c = 0; c < c_NCH; c++) begin
            check_int($sformatf("drain_queue_empty_ch%0d", c), exp_q[c].size(), 0);
            check_bit($sformatf("drain_idle_ch%0d", c), dst_valid[c], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
